// File: rtl/unpack_float_operand_pkg.sv
// Shared constants for the HCORDIC float unpacker and the matching sum packer.
// The working mantissa layout is [27]=carry, [26]=hidden, [25:3]=fraction, [2:0]=guard/round/sticky.
package unpack_float_operand_pkg;

    localparam int          FP_BIAS        = 127;
    localparam logic [7:0]  FP_EXP_SPECIAL = 8'hFF;
    localparam int          DENORM_EXP     = -126;
    localparam int          SPECIAL_EXP    = 128;
    localparam int          MANT_W         = 28;
    localparam int          HIDDEN_BIT     = 26;
    localparam int          FRAC_LSB       = 3;
    localparam int          FRAC_W         = 23;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_OUT  = 2'd2
    } state_e;

endpackage

// File: rtl/unpack_float_operand_classify.sv
// Combinational decode of an IEEE-754 single into class flags plus initial exponent
// and mantissa in the adder's sum layout. Idle slots decode to all zeros.
module float_classify
    import unpack_float_operand_pkg::*;
#(
    parameter int EXP_W = 10
) (
    input  logic [31:0]             in_float,
    input  logic                    in_idle,
    output logic                    sign,
    output logic signed [EXP_W-1:0] exp,
    output logic [MANT_W-1:0]       mant,
    output logic                    zero,
    output logic                    inf,
    output logic                    nan,
    output logic                    denorm
);

    logic [7:0]        e;
    logic [FRAC_W-1:0] f;
    logic [EXP_W-1:0]  e_ext;

    assign e     = in_float[30:23];
    assign f     = in_float[22:0];
    assign e_ext = {{(EXP_W-8){1'b0}}, e};

    always_comb begin
        sign   = 1'b0;
        exp    = '0;
        mant   = '0;
        zero   = 1'b0;
        inf    = 1'b0;
        nan    = 1'b0;
        denorm = 1'b0;
        if (!in_idle) begin
            sign = in_float[31];
            if (e == 8'd0) begin
                if (f == '0) begin
                    zero = 1'b1;
                    exp  = EXP_W'(-FP_BIAS);
                end else begin
                    // Hidden bit stays clear; the top module shifts it into place if enabled.
                    denorm                  = 1'b1;
                    exp                     = EXP_W'(DENORM_EXP);
                    mant[FRAC_LSB +: FRAC_W] = f;
                end
            end else if (e == FP_EXP_SPECIAL) begin
                exp = EXP_W'(SPECIAL_EXP);
                if (f == '0) begin
                    inf = 1'b1;
                end else begin
                    nan                      = 1'b1;
                    mant[HIDDEN_BIT]         = 1'b1;
                    mant[FRAC_LSB +: FRAC_W] = f;
                end
            end else begin
                exp                      = e_ext - EXP_W'(FP_BIAS);
                mant[HIDDEN_BIT]         = 1'b1;
                mant[FRAC_LSB +: FRAC_W] = f;
            end
        end
    end

endmodule

// File: rtl/unpack_float_operand.sv
// Front end of the HCORDIC float datapath: registers a decoded float operand and,
// optionally, normalises subnormals one bit per cycle before presenting it downstream.
module unpack_float_operand
    import unpack_float_operand_pkg::*;
#(
    parameter int EXP_W            = 10,
    parameter bit NORMALISE_DENORM = 1'b1
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic                    in_idle,
    input  logic [31:0]             in_float,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_idle,
    output logic [31:0]             out_raw,
    output logic                    out_sign,
    output logic signed [EXP_W-1:0] out_exp,
    output logic [MANT_W-1:0]       out_mant,
    output logic                    out_zero,
    output logic                    out_inf,
    output logic                    out_nan,
    output logic                    out_denorm
);

    state_e                  state_q, state_d;
    logic                    idle_q, idle_d;
    logic [31:0]             raw_q, raw_d;
    logic                    sign_q, sign_d;
    logic signed [EXP_W-1:0] exp_q, exp_d;
    logic [MANT_W-1:0]       mant_q, mant_d;
    logic                    zero_q, zero_d;
    logic                    inf_q, inf_d;
    logic                    nan_q, nan_d;
    logic                    denorm_q, denorm_d;

    logic                    c_sign, c_zero, c_inf, c_nan, c_denorm;
    logic signed [EXP_W-1:0] c_exp;
    logic [MANT_W-1:0]       c_mant;
    logic                    accept;

    float_classify #(.EXP_W(EXP_W)) u_classify (
        .in_float (in_float),
        .in_idle  (in_idle),
        .sign     (c_sign),
        .exp      (c_exp),
        .mant     (c_mant),
        .zero     (c_zero),
        .inf      (c_inf),
        .nan      (c_nan),
        .denorm   (c_denorm)
    );

    // A held output frees its slot on the same cycle it is consumed.
    assign in_ready = (state_q == S_IDLE) || ((state_q == S_OUT) && out_ready);
    assign accept   = in_valid && in_ready;

    always_comb begin
        state_d  = state_q;
        idle_d   = idle_q;
        raw_d    = raw_q;
        sign_d   = sign_q;
        exp_d    = exp_q;
        mant_d   = mant_q;
        zero_d   = zero_q;
        inf_d    = inf_q;
        nan_d    = nan_q;
        denorm_d = denorm_q;

        case (state_q)
            S_NORM: begin
                mant_d = mant_q << 1;
                exp_d  = exp_q - EXP_W'(1);
                if (mant_q[HIDDEN_BIT-1]) state_d = S_OUT;
            end
            S_OUT: begin
                if (out_ready && !in_valid) state_d = S_IDLE;
            end
            default: ;
        endcase

        if (accept) begin
            idle_d   = in_idle;
            raw_d    = in_float;
            sign_d   = c_sign;
            exp_d    = c_exp;
            mant_d   = c_mant;
            zero_d   = c_zero;
            inf_d    = c_inf;
            nan_d    = c_nan;
            denorm_d = c_denorm;
            state_d  = (c_denorm && NORMALISE_DENORM) ? S_NORM : S_OUT;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= S_IDLE;
            idle_q   <= 1'b0;
            raw_q    <= '0;
            sign_q   <= 1'b0;
            exp_q    <= '0;
            mant_q   <= '0;
            zero_q   <= 1'b0;
            inf_q    <= 1'b0;
            nan_q    <= 1'b0;
            denorm_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idle_q   <= idle_d;
            raw_q    <= raw_d;
            sign_q   <= sign_d;
            exp_q    <= exp_d;
            mant_q   <= mant_d;
            zero_q   <= zero_d;
            inf_q    <= inf_d;
            nan_q    <= nan_d;
            denorm_q <= denorm_d;
        end
    end

    assign out_valid  = (state_q == S_OUT);
    assign out_idle   = idle_q;
    assign out_raw    = raw_q;
    assign out_sign   = sign_q;
    assign out_exp    = exp_q;
    assign out_mant   = mant_q;
    assign out_zero   = zero_q;
    assign out_inf    = inf_q;
    assign out_nan    = nan_q;
    assign out_denorm = denorm_q;

endmodule
